hi_lo_acc_unit: RTL and testbench
=================================

// Module: hi_lo_acc_unit
// PURPOSE
//  HI/LO special-register unit downstream of the 32-bit ALU in the EX stage.
//  - Captures the ALU's 64-bit multiply result {ProdHi,ProdLo} for mult.
//  - Executes madd/msub as a 2-cycle 64-bit accumulate. Handles mthi/mtlo.
//  - Supplies HI/LO to the mfhi/mflo path. Asserts Busy to stall the pipeline.
// PARAMETERS
//  W  32  data width of HI and LO (the 64-bit accumulate is 2*W)
// PORTS
//  Clk      in   1   clock; all state updates on the rising edge
//  Reset    in   1   asynchronous, active-low reset
//  Valid    in   1   request strobe; Op/operands sampled when Valid=1 and Busy=0
//  Op       in   3   000 nop, 001 mult, 010 madd, 011 msub, 100 mthi, 101 mtlo
//  ProdLo   in   W   low half of the ALU product
//  ProdHi   in   W   high half of the ALU product
//  RsData   in   W   source operand for mthi/mtlo
//  Busy     out  1   accumulate in progress; upstream must hold the request
//  Drop     out  1   1-cycle pulse: Valid arrived while Busy=1, request discarded
//  HiOut    out  W   HI value for mfhi
//  LoOut    out  W   LO value for mflo
// BEHAVIOUR
//  Reset (Reset=0, async): Hi=0, Lo=0, state=IDLE, Busy=0, Drop=0, staging regs=0.
//   A reset during S_ACC aborts the accumulate; no partial write survives.
//  FSM states IDLE, S_ACC:
//   IDLE, Valid, Op=mult : Hi<=ProdHi, Lo<=ProdLo; stays IDLE; 1-cycle latency.
//   IDLE, Valid, mthi/mtlo : Hi<=RsData or Lo<=RsData; other half unchanged.
//   IDLE, Valid, madd/msub : latch ProdHi and sub flag.
//    - lo_sum[W:0] = Lo +/- ProdLo, computed as a (W+1)-bit sum with carry/borrow.
//    - Register lo_sum[W-1:0] and carry.
//    - Go to S_ACC.
//   S_ACC : Hi <= Hi +/- latched ProdHi +/- carry (msub: borrow).
//    - Lo <= staged low sum. Hi and Lo are written together at the end of S_ACC.
//    - Return to IDLE.
//   Op=nop or undefined encodings (110/111): no state change.
//  Busy = (state==S_ACC). It is combinational from the state register.
//   madd/msub occupy 2 cycles, so result reads are valid from the 3rd cycle after accept.
//  Valid=1 while Busy=1: request discarded. Drop=1 next cycle. Accumulate proceeds unaffected.
//  Arithmetic: the 64-bit value {Hi,Lo} +/- {ProdHi,ProdLo} is computed modulo 2^(2W).
//   Two's complement wrap; no overflow flag or trap.
//   Signedness is already resolved by the ALU product.
//  HiOut/LoOut: registered Hi/Lo. During S_ACC they show the pre-accumulate values.
// CONFIGURATION
//  HILO_FWD_EN defined: same-cycle bypass for mult, mthi and mtlo.
//   - Accepted in IDLE, these ops drive HiOut/LoOut combinationally with the incoming
//     value, so mfhi/mflo in the same cycle sees the new data.
//   - madd/msub are never forwarded.
//  HILO_FWD_EN undefined: HiOut/LoOut come from registers only.
//   - A new value is visible the cycle after the write.
// STRUCTURE
//  hilo_pkg: op encodings (OP_NOP..OP_MTLO), FSM state constants (ST_IDLE, ST_ACC),
//   and the default width W.
//  Sub-module addsub_w (W-bit add/sub with carry-in and carry-out). It is instantiated
//   for the low half (cin=sub) and the high half (cin=carry stage).
// TESTING
//  1. Reset low mid-S_ACC after madd -> Hi=Lo=0, Busy=0 immediately; no write after release.
//  2. mult with ProdHi=0x00000001, ProdLo=0xFFFFFFFF -> next cycle HiOut=0x00000001,
//     LoOut=0xFFFFFFFF, Busy=0.
//  3. Hi=0, Lo=0xFFFFFFFF; madd with Prod=0x0000_0000_0000_0001.
//     -> Busy=1 for 1 cycle, then Hi=0x00000001, Lo=0x00000000 (carry propagates).
//  4. Hi=0, Lo=0; msub with Prod=0x0000_0000_0000_0001 -> Hi=0xFFFFFFFF,
//     Lo=0xFFFFFFFF (borrow and 64-bit wrap).
//  5. madd accepted; Valid+mthi held during S_ACC -> Drop pulses 1 cycle; mthi not applied;
//     madd result correct.
//  6. mtlo RsData=0x12345678 with a same-cycle read.
//     -> HILO_FWD_EN: LoOut=0x12345678 that cycle; undefined: old Lo that cycle,
//        0x12345678 the next cycle.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO special-register unit.
//   - op encodings OP_NOP..OP_MTLO (3-bit; 110/111 are undefined and ignored)
//   - FSM state type state_e {ST_IDLE, ST_ACC}
//   - HILO_W: default data width of HI and LO
package hilo_pkg;

   localparam int unsigned HILO_W = 32;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_MULT = 3'b001;
   localparam logic [2:0] OP_MADD = 3'b010;
   localparam logic [2:0] OP_MSUB = 3'b011;
   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_e;

endpackage

// File: rtl/addsub_w.sv
// addsub_w: W-bit adder/subtractor with carry-in and carry-out.
//   a, b  : operands
//   sub   : 1 selects a + ~b + cin (subtract when cin carries the +1 / no-borrow)
//   cin   : carry-in
//   sum   : W-bit result
//   cout  : carry-out (for subtraction, 1 means no borrow)
module addsub_w #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W-1:0] b_eff;
   logic [W:0]   total;

   always_comb begin
      b_eff = sub ? ~b : b;
      total = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
   end

   assign sum  = total[W-1:0];
   assign cout = total[W];

endmodule

// File: rtl/hi_lo_acc_unit.sv
// hi_lo_acc_unit: HI/LO special-register unit in the EX stage.
//   mult captures {ProdHi,ProdLo}; madd/msub do a 2-cycle 64-bit accumulate
//   (low half with carry in cycle 1, high half in cycle 2); mthi/mtlo load RsData.
// Ports:
//   Clk, Reset (async, active low)
//   Valid, Op[2:0], ProdLo, ProdHi, RsData : request and operands
//   Busy  : accumulate in progress (request must be held)
//   Drop  : 1-cycle pulse, a request arrived while Busy and was discarded
//   HiOut, LoOut : HI/LO for mfhi/mflo
// Configuration macro HILO_FWD_EN: when defined, mult/mthi/mtlo accepted in IDLE
//   are bypassed combinationally onto HiOut/LoOut in the same cycle.
module hi_lo_acc_unit
   import hilo_pkg::*;
#(
   parameter int unsigned W = HILO_W
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Valid,
   input  logic [2:0]   Op,
   input  logic [W-1:0] ProdLo,
   input  logic [W-1:0] ProdHi,
   input  logic [W-1:0] RsData,
   output logic         Busy,
   output logic         Drop,
   output logic [W-1:0] HiOut,
   output logic [W-1:0] LoOut
);

   state_e       state_q, state_d;
   logic [W-1:0] hi_q, hi_d;
   logic [W-1:0] lo_q, lo_d;
   logic [W-1:0] prod_hi_q, prod_hi_d;
   logic [W-1:0] lo_sum_q, lo_sum_d;
   logic         sub_q, sub_d;
   logic         carry_q, carry_d;
   logic         drop_q, drop_d;

   logic         accept;
   logic         op_sub;
   logic         is_acc_op;
   logic [W-1:0] lo_sum;
   logic         lo_cout;
   logic [W-1:0] hi_sum;
   logic         hi_carry_unused;

   assign accept    = Valid && (state_q == ST_IDLE);
   assign op_sub    = (Op == OP_MSUB);
   assign is_acc_op = (Op == OP_MADD) || (Op == OP_MSUB);

   // Low half: for msub, cin=1 supplies the +1 of the two's complement.
   addsub_w #(.W(W)) u_lo_addsub (
      .a    (lo_q),
      .b    (ProdLo),
      .sub  (op_sub),
      .cin  (op_sub),
      .sum  (lo_sum),
      .cout (lo_cout)
   );

   // High half: staged carry (or no-borrow) from the low half.
   addsub_w #(.W(W)) u_hi_addsub (
      .a    (hi_q),
      .b    (prod_hi_q),
      .sub  (sub_q),
      .cin  (carry_q),
      .sum  (hi_sum),
      .cout (hi_carry_unused)
   );

   // State register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept && is_acc_op) state_d = ST_ACC;
         ST_ACC:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next-state; requests seen in ST_ACC are ignored here
   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      prod_hi_d = prod_hi_q;
      lo_sum_d  = lo_sum_q;
      sub_d     = sub_q;
      carry_d   = carry_q;
      if (state_q == ST_ACC) begin
         hi_d = hi_sum;
         lo_d = lo_sum_q;
      end else if (Valid) begin
         case (Op)
            OP_MULT: begin
               hi_d = ProdHi;
               lo_d = ProdLo;
            end
            OP_MADD, OP_MSUB: begin
               prod_hi_d = ProdHi;
               sub_d     = op_sub;
               lo_sum_d  = lo_sum;
               carry_d   = lo_cout;
            end
            OP_MTHI: hi_d = RsData;
            OP_MTLO: lo_d = RsData;
            default: ;
         endcase
      end
   end

   assign drop_d = Valid && (state_q == ST_ACC);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         hi_q      <= '0;
         lo_q      <= '0;
         prod_hi_q <= '0;
         lo_sum_q  <= '0;
         sub_q     <= 1'b0;
         carry_q   <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         prod_hi_q <= prod_hi_d;
         lo_sum_q  <= lo_sum_d;
         sub_q     <= sub_d;
         carry_q   <= carry_d;
         drop_q    <= drop_d;
      end
   end

   // Outputs
   always_comb begin
      Busy  = (state_q == ST_ACC);
      Drop  = drop_q;
      HiOut = hi_q;
      LoOut = lo_q;
`ifdef HILO_FWD_EN
      if (accept) begin
         case (Op)
            OP_MULT: begin
               HiOut = ProdHi;
               LoOut = ProdLo;
            end
            OP_MTHI: HiOut = RsData;
            OP_MTLO: LoOut = RsData;
            default: ;
         endcase
      end
`endif
   end

endmodule

// File: tb/tb_hi_lo_acc_unit.sv
// Bench for hi_lo_acc_unit: {HI,LO} is modelled as one 64-bit value; madd/msub
// results land after a 2-cycle occupancy. Directed cases pin the model with
// literal values, then a randomized run compares every cycle.
module tb_hi_lo_acc_unit;

   localparam int unsigned W = 32;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         Valid;
   logic [2:0]   Op;
   logic [W-1:0] ProdLo, ProdHi, RsData;
   logic         Busy, Drop;
   logic [W-1:0] HiOut, LoOut;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model
   logic [63:0] m_acc;
   logic [63:0] m_pend;
   bit          m_busy;
   bit          m_drop;

   always #5 Clk = ~Clk;

   hi_lo_acc_unit #(.W(W)) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Valid  (Valid),
      .Op     (Op),
      .ProdLo (ProdLo),
      .ProdHi (ProdHi),
      .RsData (RsData),
      .Busy   (Busy),
      .Drop   (Drop),
      .HiOut  (HiOut),
      .LoOut  (LoOut)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc  = '0;
      m_pend = '0;
      m_busy = 1'b0;
      m_drop = 1'b0;
   endtask

   // Expected outputs for the current cycle given current inputs
   task automatic check_model();
      logic [W-1:0] eh, el;
      eh = m_acc[63:32];
      el = m_acc[31:0];
`ifdef HILO_FWD_EN
      if (!m_busy && Valid) begin
         case (Op)
            3'b001: begin eh = ProdHi; el = ProdLo; end
            3'b100: eh = RsData;
            3'b101: el = RsData;
            default: ;
         endcase
      end
`endif
      check("model_busy", {63'b0, Busy}, {63'b0, m_busy});
      check("model_drop", {63'b0, Drop}, {63'b0, m_drop});
      check("model_hi", {32'b0, HiOut}, {32'b0, eh});
      check("model_lo", {32'b0, LoOut}, {32'b0, el});
   endtask

   // Effect of one rising edge on the architectural state
   task automatic model_step();
      logic [63:0] prod;
      prod = {ProdHi, ProdLo};
      if (m_busy) begin
         m_acc  = m_pend;
         m_busy = 1'b0;
         m_drop = Valid;
      end else begin
         m_drop = 1'b0;
         if (Valid) begin
            case (Op)
               3'b001: m_acc = prod;
               3'b010: begin m_pend = m_acc + prod; m_busy = 1'b1; end
               3'b011: begin m_pend = m_acc - prod; m_busy = 1'b1; end
               3'b100: m_acc[63:32] = RsData;
               3'b101: m_acc[31:0] = RsData;
               default: ;
            endcase
         end
      end
   endtask

   task automatic cycle(input logic v, input logic [2:0] op, input logic [W-1:0] ph,
                        input logic [W-1:0] pl, input logic [W-1:0] rs);
      Valid  = v;
      Op     = op;
      ProdHi = ph;
      ProdLo = pl;
      RsData = rs;
      @(negedge Clk);
      check_model();
      @(posedge Clk);
      model_step();
      #1;
   endtask

   // Drop the request so registered outputs can be read without bypass
   task automatic quiet();
      Valid = 1'b0;
      Op    = 3'b000;
      #1;
   endtask

   initial begin
      Reset  = 1'b0;
      Valid  = 1'b0;
      Op     = 3'b000;
      ProdHi = '0;
      ProdLo = '0;
      RsData = '0;
      model_reset();
      #2;
      check("rst_busy", {63'b0, Busy}, 64'd0);
      check("rst_drop", {63'b0, Drop}, 64'd0);
      check("rst_hilo", {HiOut, LoOut}, 64'd0);
      repeat (2) @(posedge Clk);
      @(negedge Clk) Reset = 1'b1;
      @(posedge Clk);
      #1;

      // mult capture
      cycle(1'b1, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0);
      quiet();
      check("mult_val", {HiOut, LoOut}, 64'h0000_0001_FFFF_FFFF);
      check("mult_busy", {63'b0, Busy}, 64'd0);

      // madd with carry from low to high half
      cycle(1'b1, 3'b100, 32'h0, 32'h0, 32'h0000_0000);
      cycle(1'b1, 3'b101, 32'h0, 32'h0, 32'hFFFF_FFFF);
      cycle(1'b1, 3'b010, 32'h0, 32'h0000_0001, 32'h0);
      quiet();
      check("madd_busy", {63'b0, Busy}, 64'd1);
      check("madd_pre", {HiOut, LoOut}, 64'h0000_0000_FFFF_FFFF);
      cycle(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      quiet();
      check("madd_done_busy", {63'b0, Busy}, 64'd0);
      check("madd_val", {HiOut, LoOut}, 64'h0000_0001_0000_0000);

      // msub borrow through 64-bit wrap
      cycle(1'b1, 3'b100, 32'h0, 32'h0, 32'h0);
      cycle(1'b1, 3'b101, 32'h0, 32'h0, 32'h0);
      cycle(1'b1, 3'b011, 32'h0, 32'h0000_0001, 32'h0);
      cycle(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      quiet();
      check("msub_val", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFFF);

      // request during S_ACC is dropped
      cycle(1'b1, 3'b100, 32'h0, 32'h0, 32'h0000_0005);
      cycle(1'b1, 3'b101, 32'h0, 32'h0, 32'h0000_0007);
      cycle(1'b1, 3'b010, 32'h0, 32'h0000_0003, 32'h0);
      cycle(1'b1, 3'b100, 32'h0, 32'h0, 32'hDEAD_BEEF);
      quiet();
      check("drop_pulse", {63'b0, Drop}, 64'd1);
      check("drop_val", {HiOut, LoOut}, 64'h0000_0005_0000_000A);
      cycle(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      quiet();
      check("drop_end", {63'b0, Drop}, 64'd0);
      check("drop_hold", {HiOut, LoOut}, 64'h0000_0005_0000_000A);

      // mtlo with a same-cycle read
      cycle(1'b1, 3'b101, 32'h0, 32'h0, 32'h0000_AAAA);
      Valid  = 1'b1;
      Op     = 3'b101;
      RsData = 32'h1234_5678;
      @(negedge Clk);
`ifdef HILO_FWD_EN
      check("mtlo_same", {32'b0, LoOut}, 64'h0000_0000_1234_5678);
`else
      check("mtlo_same", {32'b0, LoOut}, 64'h0000_0000_0000_AAAA);
`endif
      check_model();
      @(posedge Clk);
      model_step();
      #1;
      quiet();
      check("mtlo_next", {32'b0, LoOut}, 64'h0000_0000_1234_5678);

      // reset while accumulating aborts with no write
      cycle(1'b1, 3'b010, 32'h1111_1111, 32'h2222_2222, 32'h0);
      quiet();
      Reset = 1'b0;
      #1;
      model_reset();
      check("abort_busy", {63'b0, Busy}, 64'd0);
      check("abort_hilo", {HiOut, LoOut}, 64'd0);
      @(negedge Clk) Reset = 1'b1;
      @(posedge Clk);
      #1;
      cycle(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      cycle(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      quiet();
      check("abort_after", {HiOut, LoOut}, 64'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] op;
         logic       v;
         v  = ($urandom_range(0, 3) != 0);
         op = 3'($urandom_range(0, 7));
         cycle(v, op, $urandom, $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
